// File: rtl/div_addsub_seq.sv
// div_addsub_seq: sequential unsigned divider, one quotient bit per clock using a
// non-restoring add/subtract recurrence on a (width+1)-bit partial remainder.
// Ports: clk_i, rst_i (sync, active-high); operands in_valid_i/in_ready_o with A, B;
// results out_valid_o/out_ready_i with Q (quotient), R (remainder), DZ (divide by zero).

module div_addsub_step #(
    parameter int W     = 9,
    parameter int SPEED = 2
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_s
);
    localparam int N = W + 1;
    localparam int L = $clog2(N);

    logic [W-1:0] w_bx;
    logic [W-1:0] w_hp;
    logic [N-1:0] w_c;

    assign w_bx = i_b ^ {W{i_sub}};
    assign w_hp = i_a ^ w_bx;

    // Prefix position 0 carries the carry-in; position k+1 is operand bit k.
    // After the tree, position k holds the carry into operand bit k.
    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        int           j;
        g = {(i_a & w_bx), i_sub};
        p = {w_hp, 1'b0};
        j = 0;
        if (SPEED == 0) begin
            for (int i = 1; i < N; i++) begin
                g[i] = g[i] | (p[i] & g[i-1]);
                p[i] = p[i] & p[i-1];
            end
        end else if (SPEED == 1) begin
            for (int l = 0; l < L; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (((i + 1) % (2 << l)) == 0) begin
                        j    = i - (1 << l);
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
            for (int l = L - 2; l >= 0; l--) begin
                for (int i = 0; i < N; i++) begin
                    if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                        j    = i - (1 << l);
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end else begin
            for (int l = 0; l < L; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        j    = ((i >> l) << l) - 1;
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end
        w_c = g;
    end

    assign o_s = w_hp ^ w_c[W-1:0];
endmodule

module div_addsub_seq #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] Q,
    output logic [width-1:0] R,
    output logic             DZ
);
    localparam int CW = $clog2(width);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [width-1:0] r_q;
    logic [width-1:0] r_b;
    logic [width-1:0] r_qo;
    logic [width-1:0] r_ro;
    logic             r_dz;
    logic [width:0]   r_p;
    logic [width:0]   w_add_a;
    logic [width:0]   w_sum;
    logic [width:0]   w_fix;
    logic             w_calc;
    logic             w_sub;

    // CALC feeds the shifted {P,Q}; FIX reuses the same step as a plain add.
    assign w_calc  = (r_state == S_CALC);
    assign w_add_a = w_calc ? {r_p[width-1:0], r_q[width-1]} : r_p;
    assign w_sub   = w_calc && !r_p[width];
    assign w_fix   = r_p[width] ? w_sum : r_p;

    div_addsub_step #(
        .W    (width + 1),
        .SPEED(speed)
    ) u_step (
        .i_a  (w_add_a),
        .i_b  ({1'b0, r_b}),
        .i_sub(w_sub),
        .o_s  (w_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_next = (B == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_q   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_qo  <= '0;
            r_ro  <= '0;
            r_dz  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_q   <= A;
                        r_b   <= B;
                        r_p   <= '0;
                        r_cnt <= CW'(width - 1);
                        if (B == '0) begin
                            r_qo <= '1;
                            r_ro <= A;
                            r_dz <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_sum;
                    r_q   <= {r_q[width-2:0], ~w_sum[width]};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_p  <= w_fix;
                    r_qo <= r_q;
                    r_ro <= w_fix[width-1:0];
                    r_dz <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign Q  = r_qo;
    assign R  = r_ro;
    assign DZ = r_dz;
endmodule

// File: tb/tb_div_addsub_seq.sv
// tb_div_addsub_seq: directed and randomized checks of div_addsub_seq.
// Instances: width 8/Sklansky, width 8/Brent-Kung, width 13/serial.

module tb_div_addsub_seq;
    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic [2:0]       iv   = '0;
    logic [2:0]       orr  = '0;
    logic [2:0][12:0] a_in = '0;
    logic [2:0][12:0] b_in = '0;
    logic [2:0]       ir;
    logic [2:0]       ov;
    logic [2:0]       dz;
    logic [7:0]       q0, r0, q1, r1;
    logic [12:0]      q2, r2;
    logic [2:0][12:0] qa, ra;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign qa[0] = {5'd0, q0};
    assign ra[0] = {5'd0, r0};
    assign qa[1] = {5'd0, q1};
    assign ra[1] = {5'd0, r1};
    assign qa[2] = q2;
    assign ra[2] = r2;

    div_addsub_seq #(.width(8), .speed(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .A(a_in[0][7:0]), .B(b_in[0][7:0]),
        .out_valid_o(ov[0]), .out_ready_i(orr[0]),
        .Q(q0), .R(r0), .DZ(dz[0])
    );

    div_addsub_seq #(.width(8), .speed(1)) u_dut_bk (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .A(a_in[1][7:0]), .B(b_in[1][7:0]),
        .out_valid_o(ov[1]), .out_ready_i(orr[1]),
        .Q(q1), .R(r1), .DZ(dz[1])
    );

    div_addsub_seq #(.width(13), .speed(0)) u_dut_w13 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(iv[2]), .in_ready_o(ir[2]),
        .A(a_in[2]), .B(b_in[2]),
        .out_valid_o(ov[2]), .out_ready_i(orr[2]),
        .Q(q2), .R(r2), .DZ(dz[2])
    );

    function automatic logic [12:0] mask(input int k);
        return (k == 2) ? 13'h1fff : 13'h00ff;
    endfunction

    // One operation: accept, wait for result, consume it. lat counts
    // clock edges from the accept edge to the first edge seeing out_valid_o.
    task automatic do_op(input int k, input logic [12:0] a, input logic [12:0] b,
                         output logic [12:0] q, output logic [12:0] r,
                         output logic z, output int lat);
        int n;
        @(negedge clk);
        a_in[k] = a;
        b_in[k] = b;
        iv[k]   = 1'b1;
        orr[k]  = 1'b1;
        n = 0;
        while (!ir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout unit %0d in_ready_o=%0b required 1", k, ir[k]);
        end
        @(negedge clk);
        iv[k] = 1'b0;
        lat = 1;
        while (!ov[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q = qa[k];
        r = ra[k];
        z = dz[k];
        @(negedge clk);
        orr[k] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ir[k], ov[k], dz[k]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_flags unit %0d ir/ov/dz=%b required 100", k, {ir[k], ov[k], dz[k]});
            end
            checks++;
            if (qa[k] !== 13'd0 || ra[k] !== 13'd0) begin
                errors++;
                $display("FAIL reset_qr unit %0d Q=%0d R=%0d required 0 0", k, qa[k], ra[k]);
            end
        end
    endtask

    task automatic test_directed();
        int ta[4] = '{100, 255, 3, 200};
        int tb[4] = '{7, 1, 200, 200};
        int tq[4] = '{14, 255, 0, 1};
        int tr[4] = '{2, 0, 3, 0};
        logic [12:0] q, r;
        logic z;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(0, 13'(ta[i]), 13'(tb[i]), q, r, z, lat);
            checks++;
            if (q !== 13'(tq[i]) || r !== 13'(tr[i]) || z !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d Q=%0d R=%0d DZ=%0b required %0d %0d 0",
                         i, q, r, z, tq[i], tr[i]);
            end
            checks++;
            if (lat != 10) begin
                errors++;
                $display("FAIL directed_latency_%0d got %0d required 10", i, lat);
            end
        end
        checks++;
        if (qa[0] !== 13'd1 || ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold Q=%0d ov=%0b ir=%0b required 1 0 1", qa[0], ov[0], ir[0]);
        end
    endtask

    task automatic test_div_zero();
        logic [12:0] q, r;
        logic z;
        int lat;
        do_op(0, 13'd5, 13'd0, q, r, z, lat);
        checks++;
        if (q !== 13'd255 || r !== 13'd5 || z !== 1'b1) begin
            errors++;
            $display("FAIL dz_result Q=%0d R=%0d DZ=%0b required 255 5 1", q, r, z);
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL dz_latency got %0d required 1", lat);
        end
        do_op(0, 13'd9, 13'd4, q, r, z, lat);
        checks++;
        if (q !== 13'd2 || r !== 13'd1 || z !== 1'b0) begin
            errors++;
            $display("FAIL after_dz Q=%0d R=%0d DZ=%0b required 2 1 0", q, r, z);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        orr[0]  = 1'b0;
        a_in[0] = 13'd123;
        b_in[0] = 13'd10;
        iv[0]   = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || qa[0] !== 13'd12 || ra[0] !== 13'd3) begin
                errors++;
                $display("FAIL bp_hold_%0d ov=%0b ir=%0b Q=%0d R=%0d required 1 0 12 3",
                         i, ov[0], ir[0], qa[0], ra[0]);
            end
        end
        orr[0] = 1'b1;
        @(negedge clk);
        orr[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release ir=%0b ov=%0b required 1 0", ir[0], ov[0]);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [12:0] q, r;
        logic z;
        int lat;
        logic seen;
        @(negedge clk);
        a_in[0] = 13'd77;
        b_in[0] = 13'd5;
        iv[0]   = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ir[0], ov[0], dz[0]} !== 3'b100 || qa[0] !== 13'd0 || ra[0] !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset ir/ov/dz=%b Q=%0d R=%0d required 100 0 0",
                     {ir[0], ov[0], dz[0]}, qa[0], ra[0]);
        end
        orr[0] = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        orr[0] = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_result out_valid_o seen=%0b required 0", seen);
        end
        do_op(0, 13'd77, 13'd5, q, r, z, lat);
        checks++;
        if (q !== 13'd15 || r !== 13'd2 || z !== 1'b0) begin
            errors++;
            $display("FAIL after_reset Q=%0d R=%0d DZ=%0b required 15 2 0", q, r, z);
        end
    endtask

    task automatic test_random(input int k, input int nops);
        logic [12:0] m;
        logic [12:0] eq[$], er[$], ea[$], eb[$];
        logic        ez[$];
        logic [12:0] a, b, xq, xr, xa, xb;
        logic        xz, fired, seen;
        int acc, got, cyc, sel;
        m = mask(k);
        acc = 0;
        got = 0;
        cyc = 0;
        fired = 1'b0;
        iv[k] = 1'b0;
        orr[k] = 1'b0;
        while (got < nops && cyc < nops * 60) begin
            @(negedge clk);
            cyc++;
            if (fired) begin
                iv[k] = 1'b0;
                fired = 1'b0;
            end
            orr[k] = ($urandom_range(0, 3) != 0);
            if (ov[k] && orr[k]) begin
                got++;
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious unit %0d Q=%0d R=%0d required no result", k, qa[k], ra[k]);
                end else begin
                    xq = eq.pop_front();
                    xr = er.pop_front();
                    xz = ez.pop_front();
                    xa = ea.pop_front();
                    xb = eb.pop_front();
                    if (qa[k] !== xq || ra[k] !== xr || dz[k] !== xz) begin
                        errors++;
                        $display("FAIL rnd_result unit %0d A=%0d B=%0d got Q=%0d R=%0d DZ=%0b required %0d %0d %0b",
                                 k, xa, xb, qa[k], ra[k], dz[k], xq, xr, xz);
                    end
                    if (!xz) begin
                        checks++;
                        if (int'(qa[k]) * int'(xb) + int'(ra[k]) != int'(xa) || ra[k] >= xb) begin
                            errors++;
                            $display("FAIL rnd_identity unit %0d A=%0d B=%0d got Q=%0d R=%0d required Q*B+R=A R<B",
                                     k, xa, xb, qa[k], ra[k]);
                        end
                    end
                end
            end
            if (!iv[k] && acc < nops && $urandom_range(0, 2) != 0) begin
                a = ($urandom_range(0, 9) == 0) ? m : (13'($urandom) & m);
                sel = $urandom_range(0, 7);
                if (sel == 0) b = 13'd0;
                else if (sel < 3) b = 13'($urandom_range(1, 15));
                else b = 13'($urandom) & m;
                a_in[k] = a;
                b_in[k] = b;
                iv[k] = 1'b1;
            end
            if (iv[k] && ir[k]) begin
                fired = 1'b1;
                acc++;
                ea.push_back(a_in[k]);
                eb.push_back(b_in[k]);
                ez.push_back(b_in[k] == 13'd0);
                eq.push_back((b_in[k] == 13'd0) ? m : a_in[k] / b_in[k]);
                er.push_back((b_in[k] == 13'd0) ? a_in[k] : a_in[k] % b_in[k]);
            end
        end
        @(negedge clk);
        iv[k] = 1'b0;
        orr[k] = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ov[k]) seen = 1'b1;
        end
        orr[k] = 1'b0;
        checks++;
        if (got != nops || eq.size() != 0 || seen) begin
            errors++;
            $display("FAIL rnd_count unit %0d results=%0d pending=%0d extra=%0b required %0d 0 0",
                     k, got, eq.size(), seen, nops);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        for (int k = 0; k < 3; k++) begin
            test_random(k, 1000);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
